// File: rtl/sramlike_dm_cache_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_pkg
//  Brief    : Shared types for sramlike_dm_cache. Holds the controller state
//             encoding, the sram-like size codes and the byte-lane mask
//             helper.
//  Revision : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // sram-like transfer size codes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Controller states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    UC_REQ    = 3'd4,
    UC_WAIT   = 3'd5,
    WR_REQ    = 3'd6,
    WR_WAIT   = 3'd7
  } state_t;

  // Byte lanes touched by an access. Size 3 behaves like a word access.
  function automatic logic [3:0] byte_mask(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: byte_mask = 4'b0001 << addr_lo;
      SIZE_HALF: byte_mask = 4'b0011 << {addr_lo[1], 1'b0};
      default:   byte_mask = 4'hF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sramlike_dm_cache_if.sv
`default_nettype none
// ============================================================================
//  Module   : sramlike_dm_cache_if
//  Brief    : Single-beat sram-like bus. The master issues req/wr/size/addr/
//             wdata; the slave answers with addr_ok, data_ok and rdata.
//  Revision : 1.0 - initial release
// ============================================================================
interface sramlike_dm_cache_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata,
                  input  rdata, addr_ok, data_ok);
  modport slave  (input  req, wr, size, addr, wdata,
                  output rdata, addr_ok, data_ok);
endinterface
`default_nettype wire

// File: rtl/sramlike_dm_cache_line_array.sv
`default_nettype none
// ============================================================================
//  Module   : cache_line_array
//  Brief    : Direct-mapped line storage: valid/tag/one 32-bit word per line.
//             Combinational read, byte-masked write, whole-line fill, and a
//             synchronous clear of every valid bit on rst.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_line_array #(
  parameter int INDEX_WIDTH = 7
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic [INDEX_WIDTH-1:0]  i_rd_index,
  output logic                         o_rd_valid,
  output logic [29-INDEX_WIDTH:0]      o_rd_tag,
  output logic [31:0]                  o_rd_data,
  input  wire logic                    i_wr_en,
  input  wire logic [INDEX_WIDTH-1:0]  i_wr_index,
  input  wire logic [3:0]              i_wr_mask,
  input  wire logic [31:0]             i_wr_data,
  input  wire logic                    i_fill_en,
  input  wire logic [INDEX_WIDTH-1:0]  i_fill_index,
  input  wire logic [29-INDEX_WIDTH:0] i_fill_tag,
  input  wire logic [31:0]             i_fill_data
);

  localparam int C_LINES     = 1 << INDEX_WIDTH;
  localparam int C_TAG_WIDTH = 30 - INDEX_WIDTH;

  logic [C_LINES-1:0]     r_valid;
  logic [C_TAG_WIDTH-1:0] r_tag  [C_LINES];
  logic [31:0]            r_data [C_LINES];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

  // Valid bits: cleared together on rst, set by a fill
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_fill_en) begin
      r_valid[i_fill_index] <= 1'b1;
    end
  end

  // Tag/data payload: no reset needed since valid guards every use
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (i_fill_en) begin
        r_tag[i_fill_index]  <= i_fill_tag;
        r_data[i_fill_index] <= i_fill_data;
      end else if (i_wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (i_wr_mask[b]) begin
            r_data[i_wr_index][8*b +: 8] <= i_wr_data[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sramlike_dm_cache.sv
`default_nettype none
// ============================================================================
//  Module   : sramlike_dm_cache
//  Brief    : Direct-mapped, write-through, no-write-allocate one-word-line
//             cache between an sram-like CPU bridge and the AXI bridge.
//             Addresses inside the UC_BASE/UC_MASK window bypass the array.
//             Optional: define CACHE_PERF_CNT_EN to add hit_cnt/miss_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module sramlike_dm_cache
  import cache_pkg::*;
#(
  parameter int          INDEX_WIDTH = 7,
  parameter logic [31:0] UC_BASE     = 32'h1FAF_0000,
  parameter logic [31:0] UC_MASK     = 32'hFFFF_0000
) (
  input  wire logic           clk,
  input  wire logic           rst,
  sramlike_dm_cache_if.slave  cpu,
  sramlike_dm_cache_if.master mem
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]         hit_cnt,
  output logic [31:0]         miss_cnt
`endif
);

  localparam int C_TAG_WIDTH = 30 - INDEX_WIDTH;

  state_t r_state;
  state_t w_next_state;

  logic                   r_wr;
  logic [1:0]             r_size;
  logic [31:0]            r_addr;
  logic [31:0]            r_wdata;

  logic                   w_rd_valid;
  logic [C_TAG_WIDTH-1:0] w_rd_tag;
  logic [31:0]            w_rd_data;
  logic                   w_uncached;
  logic                   w_hit;
  logic                   w_accept;
  logic                   w_wr_en;
  logic                   w_fill_en;
  logic [3:0]             w_mask;
  logic [INDEX_WIDTH-1:0] w_index;
  logic [C_TAG_WIDTH-1:0] w_tag;

  assign w_index    = r_addr[INDEX_WIDTH+1:2];
  assign w_tag      = r_addr[31:INDEX_WIDTH+2];
  assign w_uncached = (r_addr & UC_MASK) == UC_BASE;
  assign w_hit      = w_rd_valid && (w_rd_tag == w_tag) && !w_uncached;
  assign w_mask     = byte_mask(r_size, r_addr[1:0]);
  assign w_accept   = (r_state == IDLE) && cpu.req;

  cache_line_array #(
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_lines (
    .clk          (clk),
    .rst          (rst),
    .i_rd_index   (w_index),
    .o_rd_valid   (w_rd_valid),
    .o_rd_tag     (w_rd_tag),
    .o_rd_data    (w_rd_data),
    .i_wr_en      (w_wr_en),
    .i_wr_index   (w_index),
    .i_wr_mask    (w_mask),
    .i_wr_data    (r_wdata),
    .i_fill_en    (w_fill_en),
    .i_fill_index (w_index),
    .i_fill_tag   (w_tag),
    .i_fill_data  (mem.rdata)
  );

  // Latch the accepted request; it stays put for the whole transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_size  <= SIZE_BYTE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr    <= cpu.wr;
      r_size  <= cpu.size;
      r_addr  <= cpu.addr;
      r_wdata <= cpu.wdata;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (cpu.req) w_next_state = LOOKUP;
      LOOKUP: begin
        if (r_wr)            w_next_state = WR_REQ;
        else if (w_hit)      w_next_state = IDLE;
        else if (w_uncached) w_next_state = UC_REQ;
        else                 w_next_state = MISS_REQ;
      end
      MISS_REQ:  if (mem.addr_ok) w_next_state = MISS_WAIT;
      MISS_WAIT: if (mem.data_ok) w_next_state = IDLE;
      UC_REQ:    if (mem.addr_ok) w_next_state = UC_WAIT;
      UC_WAIT:   if (mem.data_ok) w_next_state = IDLE;
      WR_REQ:    if (mem.addr_ok) w_next_state = WR_WAIT;
      WR_WAIT:   if (mem.data_ok) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  // Outputs and array strobes; rst forces everything to its idle value so a
  // response arriving together with rst is swallowed
  always_comb begin
    cpu.addr_ok = 1'b0;
    cpu.data_ok = 1'b0;
    cpu.rdata   = '0;
    mem.req     = 1'b0;
    mem.wr      = 1'b0;
    mem.size    = SIZE_BYTE;
    mem.addr    = '0;
    mem.wdata   = '0;
    w_wr_en     = 1'b0;
    w_fill_en   = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: cpu.addr_ok = cpu.req;
        LOOKUP: begin
          if (r_wr) begin
            w_wr_en = w_hit;
          end else if (w_hit) begin
            cpu.data_ok = 1'b1;
            cpu.rdata   = w_rd_data;
          end
        end
        MISS_REQ: begin
          mem.req  = 1'b1;
          mem.size = SIZE_WORD;
          mem.addr = {r_addr[31:2], 2'b00};
        end
        MISS_WAIT: begin
          if (mem.data_ok) begin
            w_fill_en   = 1'b1;
            cpu.data_ok = 1'b1;
            cpu.rdata   = mem.rdata;
          end
        end
        UC_REQ: begin
          mem.req  = 1'b1;
          mem.size = r_size;
          mem.addr = r_addr;
        end
        UC_WAIT: begin
          if (mem.data_ok) begin
            cpu.data_ok = 1'b1;
            cpu.rdata   = mem.rdata;
          end
        end
        WR_REQ: begin
          mem.req   = 1'b1;
          mem.wr    = 1'b1;
          mem.size  = r_size;
          mem.addr  = r_addr;
          mem.wdata = r_wdata;
        end
        WR_WAIT: cpu.data_ok = mem.data_ok;
        default: ;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Cached reads are classified once, in LOOKUP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == LOOKUP && !r_wr && !w_uncached) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/sramlike_dm_cache.md
# sramlike_dm_cache

Parametrised direct-mapped, write-through, no-write-allocate cache sitting between the CPU-side sram-like bridges (i_sram2sramlike / d_sram2sramlike) and cpu_axi_interface, replacing the pass-through dummy cache. One instance per channel (inst, data). Both sides are sram-like single-beat interfaces, and one transaction is outstanding at a time. A configurable physical address window bypasses the cache (uncached), for MMIO/confreg.

## Interface
- INDEX_WIDTH, 7: log2 of line count; a line is one 32-bit word.
- UC_BASE, 32'h1FAF_0000: base of the uncached window.
- UC_MASK, 32'hFFFF_0000: an address is uncached iff (addr & UC_MASK) == UC_BASE.
- clk  in  1: single clock; all state updates on posedge.
- rst  in  1: synchronous, active-high reset.
- cpu_req / cpu_wr  in  1 / 1: request; 1 = write.
- cpu_size  in  2: 0 = byte, 1 = half, 2 = word.
- cpu_addr / cpu_wdata  in  32 / 32: physical address; write data.
- cpu_rdata  out  32: read data, valid with cpu_data_ok.
- cpu_addr_ok / cpu_data_ok  out  1 / 1: request accepted; response done.
- cache_req / cache_wr / cache_size  out  1 / 1 / 2: downstream request.
- cache_addr / cache_wdata  out  32 / 32: downstream address and data.
- cache_rdata  in  32: downstream read data.
- cache_addr_ok / cache_data_ok  in  1 / 1: downstream handshake.

## Operation
- The address splits as tag = addr[31:INDEX_WIDTH+2], index = addr[INDEX_WIDTH+1:2]. Each line stores valid, tag and a 32-bit word.
- States:
  - IDLE: cpu_addr_ok = cpu_req. On acceptance, latch wr/size/addr/wdata and go to LOOKUP.
  - LOOKUP: hit = valid & tag match & !uncached.
    - Read hit: return the word with cpu_data_ok, then go to IDLE.
    - Read miss, cached: go to MISS_REQ.
    - Uncached read: go to UC_REQ.
    - Any write: on a cached hit, merge wdata into the line under the byte mask; then go to WR_REQ.
  - MISS_REQ: cache_req=1, cache_wr=0, cache_size=2, word-aligned address. Go to MISS_WAIT on cache_addr_ok.
  - MISS_WAIT: on cache_data_ok, fill the line (valid=1, tag, data), pass cache_rdata to cpu_rdata with cpu_data_ok, then go to IDLE.
  - UC_REQ / UC_WAIT: as MISS_*, but forward the original size and address, and never fill.
  - WR_REQ / WR_WAIT: forward the write (original size, address and wdata). Go to WR_WAIT on cache_addr_ok. On cache_data_ok, assert cpu_data_ok and go to IDLE.
- Byte mask: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'hF. Size 3 is treated as word.
- Uncached writes are identical to cached write misses: no line update.
- Reads return the full aligned word; the CPU extracts the byte or half itself.

## Timing
- Reset values: all line valid bits = 0, state = IDLE, cpu_addr_ok = 0, cpu_data_ok = 0, cpu_rdata = 0, cache_req = 0, cache_wr = 0, cache_size = 0, cache_addr = 0, cache_wdata = 0.
- Read hit: addr_ok in cycle 0, data_ok in cycle 1. Latency is 1, with one request per 2 cycles.
- Miss, uncached or write: data_ok arrives in the same cycle as cache_data_ok, a combinational pass-through of cache_rdata.
- cache_req and its payload stay stable from assertion until cache_addr_ok; cache_req drops the cycle after.
- cpu_addr_ok is 0 in every state except IDLE. Requests during a busy period wait; a pending cpu_req is honoured in the first IDLE cycle.
- cpu_data_ok and cache_addr_ok are one-cycle pulses.
- Write hit, then read of the same address: the second read hits and returns the merged data. The array updates in LOOKUP, before any subsequent acceptance.
- cache_data_ok in the same cycle as rst: rst wins. State goes to IDLE, all lines are invalidated, no fill happens and no cpu_data_ok is asserted. Downstream is reset in the same cycle.
- Index wrap: the line count is 2^INDEX_WIDTH. Addresses differing only in tag evict each other.

## Configuration
- CACHE_PERF_CNT_EN defined: adds outputs hit_cnt [31:0] and miss_cnt [31:0], both reset to 0.
  - A cached read hit increments hit_cnt in LOOKUP.
  - A cached read miss increments miss_cnt in LOOKUP.
  - Counters wrap at 2^32. Writes and uncached accesses are not counted.
- Undefined: neither port nor counter logic exists; behaviour is otherwise identical.

## Structure
- Shared package cache_pkg holds:
  - the state enum (IDLE, LOOKUP, MISS_REQ, MISS_WAIT, UC_REQ, UC_WAIT, WR_REQ, WR_WAIT);
  - size encodings SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2;
  - the byte-mask function.
- Sub-module cache_line_array (parameter INDEX_WIDTH):
  - ports: combinational read of valid, tag and data; synchronous write with byte mask; fill.
  - global synchronous valid clear on rst.

## Test plan
- Cold read of 0x0000_0100: MISS_REQ with cache_addr=0x100 and cache_size=2. Downstream returns 0xDEADBEEF after 3 cycles; cpu_data_ok pulses with rdata=0xDEADBEEF. Rereading hits with data_ok 1 cycle after addr_ok and no cache_req.
- Byte write 0xAA to 0x102, a hit on the line above: the write is forwarded with size 0. The next read of 0x100 hits and returns 0xDEAABEEF.
- Conflict: read 0x100 then 0x100+(4<<INDEX_WIDTH) (0x300 for INDEX_WIDTH=7). The second read misses and refills; a read of 0x100 then misses again.
- Uncached read of 0x1FAF_F000 twice: both reads go downstream with the original size, and there is no fill.
- Write miss to 0x200: forwarded, no allocate. The following read of 0x200 misses.
- rst asserted during MISS_WAIT coincident with cache_data_ok: no cpu_data_ok, all outputs at reset values. The next read of 0x100 misses.
